line_echo: RTL and testbench

- Line-buffered echo stage between the on-chip UART receiver (data_out/valid/ready) and the UART transmitter (data_in/valid/ready) inside top.
- Replaces the single-character echo with line-at-a-time echo. Collects received bytes into a line buffer with backspace editing.
- On carriage return, replays the buffered line, then appends CR LF.

---
 rtl/line_echo_pkg.sv | 24 ++
 rtl/line_buffer.sv | 28 ++
 rtl/line_echo.sv | 138 +++++++++++++
 tb/tb_line_echo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_echo_pkg.sv
// line_echo_pkg: shared constants and types for the line echo stage.
//   - ASCII control characters recognised by the line editor
//   - FSM state encoding
//   - to_upper helper used on store when case conversion is enabled
package line_echo_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        TERM_CR = 2'd2,
        TERM_LF = 2'd3
    } state_t;

    // Maps 'a'..'z' onto 'A'..'Z'; every other byte passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH x 8 storage for one text line.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  synchronous write port
//   raddr_i/rdata_o       combinational read port
// Contents are not reset; the owner tracks how many entries are valid.
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_echo.sv
// line_echo: line-at-a-time echo between UART receiver and transmitter.
//   clk, reset            clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready  byte stream from the receiver
//   tx_data/tx_valid/tx_ready  byte stream to the transmitter
//   overflow              sticky: a character was dropped from this line
//   busy                  high while a line (or its CR LF) is being replayed
// Bytes are collected with backspace editing; CR replays the line then CR LF.
module line_echo
    import line_echo_pkg::*;
#(
    parameter int LINE_DEPTH = 32,
    parameter bit UPPERCASE  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(LINE_DEPTH);
    localparam int CW = AW + 1;   // holds LINE_DEPTH itself without wrapping

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           ovf_q, ovf_d;

    logic           buf_we;
    logic [7:0]     buf_wdata;
    logic [7:0]     buf_rdata;
    logic           rx_fire, tx_fire;

    line_buffer #(.DEPTH(LINE_DEPTH), .AW(AW)) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (buf_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    // Everything is decoded from the state register so that reset
    // drops tx_valid asynchronously.
    assign rx_ready = (state_q == COLLECT);
    assign tx_valid = (state_q != COLLECT);
    assign busy     = tx_valid;
    assign overflow = ovf_q;
    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;

    assign buf_wdata = UPPERCASE ? to_upper(rx_data) : rx_data;

    always_comb begin
        case (state_q)
            FLUSH:   tx_data = buf_rdata;
            TERM_CR: tx_data = CHAR_CR;
            TERM_LF: tx_data = CHAR_LF;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        buf_we   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (rx_fire) begin
                    if (rx_data == CHAR_CR) begin
                        if (count_q == '0) begin
                            state_d = TERM_CR;
                        end else begin
                            rd_ptr_d = '0;
                            state_d  = FLUSH;
                        end
                    end else if (rx_data == CHAR_LF) begin
                        // dropped so CR LF terminals don't echo blank lines
                    end else if (rx_data == CHAR_BS || rx_data == CHAR_DEL) begin
                        if (count_q != '0) begin
                            count_d = count_q - CW'(1);
                        end
                    end else if (count_q < CW'(LINE_DEPTH)) begin
                        buf_we  = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (tx_fire) begin
                    if ({1'b0, rd_ptr_q} == count_q - CW'(1)) begin
                        state_d = TERM_CR;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            TERM_CR: begin
                if (tx_fire) begin
                    state_d = TERM_LF;
                end
            end
            TERM_LF: begin
                if (tx_fire) begin
                    state_d  = COLLECT;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_line_echo.sv
// tb_line_echo: directed bench for line_echo. Two instances share the
// clock and reset: dut0 with UPPERCASE=0, dut1 with UPPERCASE=1; sel
// steers stimulus to one of them and muxes its outputs for checking.
module tb_line_echo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic       sel;

    logic [7:0] tx_data0, tx_data1;
    logic       rx_ready0, rx_ready1, tx_valid0, tx_valid1;
    logic       ovf0, ovf1, busy0, busy1;

    logic [7:0] tx_data_m;
    logic       rx_ready_m, tx_valid_m, ovf_m, busy_m;

    always #5 clk = ~clk;

    line_echo #(.LINE_DEPTH(32), .UPPERCASE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & ~sel),
        .rx_ready(rx_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready & ~sel), .overflow(ovf0), .busy(busy0)
    );

    line_echo #(.LINE_DEPTH(32), .UPPERCASE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & sel),
        .rx_ready(rx_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready & sel), .overflow(ovf1), .busy(busy1)
    );

    assign tx_data_m  = sel ? tx_data1  : tx_data0;
    assign rx_ready_m = sel ? rx_ready1 : rx_ready0;
    assign tx_valid_m = sel ? tx_valid1 : tx_valid0;
    assign ovf_m      = sel ? ovf1      : ovf0;
    assign busy_m     = sel ? busy1     : busy0;

    int n_checks = 0;
    int n_fail   = 0;

    // Handshake monitor: inputs change only #1 after posedge, so the
    // values seen at negedge are the ones the next posedge acts on.
    logic [7:0] txq[$];
    int         busy_hs;
    int         ovf_hs;
    always @(negedge clk) begin
        if (!reset && tx_valid_m && tx_ready) begin
            txq.push_back(tx_data_m);
            if (busy_m) busy_hs++;
            if (ovf_m)  ovf_hs++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_ready_m) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rx_ready_wait", int'(ok), 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_m && rx_ready_m) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", int'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_mon();
        txq.delete();
        busy_hs = 0;
        ovf_hs  = 0;
    endtask

    typedef struct {
        bit         dut;
        int         nin;
        logic [7:0] in_b[40];
        int         nexp;
        logic [7:0] exp_b[40];
        bit         ovf_pre;   // overflow expected just before the last input
    } vec_t;

    vec_t vecs[5];

    function automatic void add_in(int v, logic [7:0] b);
        vecs[v].in_b[vecs[v].nin] = b;
        vecs[v].nin++;
    endfunction

    function automatic void add_exp(int v, logic [7:0] b);
        vecs[v].exp_b[vecs[v].nexp] = b;
        vecs[v].nexp++;
    endfunction

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        sel      = 1'b0;
        clear_mon();

        for (int v = 0; v < 5; v++) begin
            vecs[v].nin = 0; vecs[v].nexp = 0; vecs[v].ovf_pre = 1'b0; vecs[v].dut = 1'b0;
        end
        // "hi" CR
        add_in(0, 8'h68); add_in(0, 8'h69); add_in(0, 8'h0D);
        add_exp(0, 8'h68); add_exp(0, 8'h69); add_exp(0, 8'h0D); add_exp(0, 8'h0A);
        // "abc" BS "d" CR, upper-casing instance
        vecs[1].dut = 1'b1;
        add_in(1, 8'h61); add_in(1, 8'h62); add_in(1, 8'h63); add_in(1, 8'h08);
        add_in(1, 8'h64); add_in(1, 8'h0D);
        add_exp(1, 8'h41); add_exp(1, 8'h42); add_exp(1, 8'h44); add_exp(1, 8'h0D); add_exp(1, 8'h0A);
        // lone CR then LF: only one CR LF comes back
        add_in(2, 8'h0D); add_in(2, 8'h0A);
        add_exp(2, 8'h0D); add_exp(2, 8'h0A);
        // 34 printable bytes: only the first 32 survive
        for (int i = 0; i < 34; i++) add_in(3, 8'h30 + 8'(i));
        add_in(3, 8'h0D);
        for (int i = 0; i < 32; i++) add_exp(3, 8'h30 + 8'(i));
        add_exp(3, 8'h0D); add_exp(3, 8'h0A);
        vecs[3].ovf_pre = 1'b1;
        // BS/DEL on empty line ignored, DEL erases, uppercase input untouched
        add_in(4, 8'h08); add_in(4, 8'h7F); add_in(4, 8'h41); add_in(4, 8'h7F);
        add_in(4, 8'h5A); add_in(4, 8'h0D);
        add_exp(4, 8'h5A); add_exp(4, 8'h0D); add_exp(4, 8'h0A);

        // reset state of both instances
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_tx_valid", int'(tx_valid_m), 0);
            chk("rst_rx_ready", int'(rx_ready_m), 1);
            chk("rst_busy",     int'(busy_m),     0);
            chk("rst_overflow", int'(ovf_m),      0);
            chk("rst_tx_data",  int'(tx_data_m),  0);
        end
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // table-driven lines
        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].dut;
            clear_mon();
            for (int k = 0; k < vecs[v].nin; k++) begin
                if (k == vecs[v].nin - 1) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_ovf_pre", v), int'(ovf_m), int'(vecs[v].ovf_pre));
                end
                send_byte(vecs[v].in_b[k]);
            end
            wait_idle();
            chk($sformatf("v%0d_len", v), txq.size(), vecs[v].nexp);
            for (int k = 0; k < vecs[v].nexp && k < txq.size(); k++)
                chk($sformatf("v%0d_tx%0d", v, k), int'(txq[k]), int'(vecs[v].exp_b[k]));
            chk($sformatf("v%0d_busy_hs", v), busy_hs, vecs[v].nexp);
            chk($sformatf("v%0d_ovf_hs", v), ovf_hs, vecs[v].ovf_pre ? vecs[v].nexp : 0);
            chk($sformatf("v%0d_ovf_post", v), int'(ovf_m), 0);
            chk($sformatf("v%0d_rx_ready", v), int'(rx_ready_m), 1);
        end

        // stall mid-FLUSH: output held, receive side closed
        begin
            bit held = 1'b1;
            bit rx_closed = 1'b1;
            sel = 1'b0;
            clear_mon();
            tx_ready = 1'b0;
            send_byte(8'h6D); send_byte(8'h6E); send_byte(8'h6F); send_byte(8'h0D);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tx_valid_m !== 1'b1 || tx_data_m !== 8'h6D) held = 1'b0;
                if (rx_ready_m !== 1'b0) rx_closed = 1'b0;
                rx_data  = 8'h55;
                rx_valid = i[0];
            end
            chk("stall_held", int'(held), 1);
            chk("stall_rx_closed", int'(rx_closed), 1);
            rx_valid = 1'b0;
            tx_ready = 1'b1;
            wait_idle();
            chk("stall_len", txq.size(), 5);
            if (txq.size() == 5) begin
                chk("stall_tx0", int'(txq[0]), 8'h6D);
                chk("stall_tx2", int'(txq[2]), 8'h6F);
                chk("stall_tx4", int'(txq[4]), 8'h0A);
            end
            // if a 0x55 had slipped in, this CR would replay it
            clear_mon();
            send_byte(8'h0D);
            wait_idle();
            chk("stall_empty_len", txq.size(), 2);
        end

        // reset mid-FLUSH abandons the line
        begin
            sel = 1'b0;
            tx_ready = 1'b0;
            send_byte(8'h78); send_byte(8'h79); send_byte(8'h7A); send_byte(8'h0D);
            @(negedge clk);
            chk("midrst_pre_valid", int'(tx_valid_m), 1);
            @(posedge clk);
            #1 reset = 1'b1;
            #1;
            chk("midrst_tx_valid", int'(tx_valid_m), 0);
            chk("midrst_busy",     int'(busy_m),     0);
            chk("midrst_rx_ready", int'(rx_ready_m), 1);
            @(posedge clk);
            #1 reset = 1'b0;
            tx_ready = 1'b1;
            clear_mon();
            send_byte(8'h71); send_byte(8'h0D);
            wait_idle();
            chk("midrst_len", txq.size(), 3);
            if (txq.size() == 3) begin
                chk("midrst_tx0", int'(txq[0]), 8'h71);
                chk("midrst_tx1", int'(txq[1]), 8'h0D);
                chk("midrst_tx2", int'(txq[2]), 8'h0A);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
